// File: rtl/posit_pkg.sv
// Shared posit definitions: default geometry, special patterns and the decoded-value
// bundle that the arithmetic front ends hand to the encoder.
package posit_pkg;

  localparam int unsigned POSIT_N  = 8;
  localparam int unsigned POSIT_ES = 3;
  localparam int unsigned POSIT_RS = $clog2(POSIT_N);
  localparam int unsigned POSIT_FW = POSIT_N;
  localparam int unsigned POSIT_SW = POSIT_ES + POSIT_RS + 1;

  localparam logic [POSIT_N-1:0] POSIT_NAR  = {1'b1, {(POSIT_N-1){1'b0}}};
  localparam logic [POSIT_N-1:0] POSIT_ZERO = '0;

  localparam logic [POSIT_N-2:0] POSIT_MAXPOS_BODY = '1;
  localparam logic [POSIT_N-2:0] POSIT_MINPOS_BODY = {{(POSIT_N-2){1'b0}}, 1'b1};

  typedef struct packed {
    logic                sign;
    logic [POSIT_SW-1:0] scale;
    logic [POSIT_FW-1:0] frac;
    logic                sticky;
    logic                zero;
    logic                nar;
  } posit_dec_t;

endpackage

// File: rtl/posit_round_rne.sv
// Round-to-nearest-even on a posit body; a carry out of the body clamps to maxpos.
module posit_round_rne
  import posit_pkg::*;
#(
  parameter int unsigned BW = POSIT_N - 1
) (
  input  logic [BW-1:0] body,
  input  logic          l,
  input  logic          g,
  input  logic          r,
  input  logic          s,
  output logic [BW-1:0] rounded,
  output logic          ovf
);

  logic [BW:0] sum;

  always_comb begin
    sum     = {1'b0, body} + {{BW{1'b0}}, (g & (r | s | l))};
    ovf     = sum[BW];
    rounded = ovf ? '1 : sum[BW-1:0];
  end

endmodule

// File: rtl/posit_encoder_pipe.sv
// Three-stage posit pack-and-round pipeline: field split, regime shift, round/sign/specials,
// with a single global advance shared by all stages.
module posit_encoder_pipe
  import posit_pkg::*;
#(
  parameter int unsigned N  = POSIT_N,
  parameter int unsigned ES = POSIT_ES,
  parameter int unsigned RS = $clog2(N),
  parameter int unsigned FW = N,
  parameter int unsigned SW = ES + RS + 1
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sign,
  input  logic [SW-1:0] in_scale,
  input  logic [FW-1:0] in_frac,
  input  logic          in_sticky,
  input  logic          in_zero,
  input  logic          in_nar,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_posit
);

  localparam int unsigned KW = SW - ES;
  localparam int unsigned VW = N + ES + FW;
  localparam logic signed [KW-1:0] K_MAX = KW'(N - 2);
  localparam logic signed [KW-1:0] K_MIN = -K_MAX;
  localparam logic [N-1:0]   NAR    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-2:0]   MAXPOS = '1;
  localparam logic [N-2:0]   MINPOS = {{(N-2){1'b0}}, 1'b1};

  typedef struct packed {
    logic          sign;
    logic [KW-1:0] k;
    logic [ES-1:0] e;
    logic [FW-1:0] frac;
    logic          sticky;
    logic          zero;
    logic          nar;
    logic          sat_hi;
    logic          sat_lo;
  } s1_t;

  typedef struct packed {
    logic         sign;
    logic [N-2:0] body;
    logic         g;
    logic         r;
    logic         s;
    logic         sat_hi;
    logic         sat_lo;
    logic         zero;
    logic         nar;
  } s2_t;

  logic v1, v2, adv;
  s1_t  s1, s1_next;
  s2_t  s2, s2_next;

  assign adv      = out_ready | ~out_valid;
  assign in_ready = adv;

  // Stage 1: the floor of scale/2^ES is simply the upper slice of the signed scale.
  logic signed [KW-1:0] k_in;

  always_comb begin
    k_in           = $signed(in_scale[SW-1:ES]);
    s1_next        = '0;
    s1_next.sign   = in_sign;
    s1_next.k      = k_in;
    s1_next.e      = in_scale[ES-1:0];
    s1_next.frac   = in_frac;
    s1_next.sticky = in_sticky;
    s1_next.zero   = in_zero;
    s1_next.nar    = in_nar;
    s1_next.sat_hi = (k_in > K_MAX);
    s1_next.sat_lo = (k_in < K_MIN);
  end

  // Stage 2: seed {~neg, neg} and arithmetic-shift; the fill bit builds the run of ones (k >= 0)
  // or zeros (k < 0), with ~k as the shift so that -k zeros precede the terminating 1.
  logic          kneg;
  logic [RS-1:0] shamt;
  logic [VW-1:0] vec, shifted;

  always_comb begin
    kneg         = s1.k[KW-1];
    shamt        = kneg ? ~s1.k[RS-1:0] : s1.k[RS-1:0];
    vec          = {~kneg, kneg, s1.e, s1.frac, {(N-2){1'b0}}};
    shifted      = $signed(vec) >>> shamt;
    s2_next        = '0;
    s2_next.sign   = s1.sign;
    s2_next.body   = shifted[VW-1 -: N-1];
    s2_next.g      = shifted[VW-N];
    s2_next.r      = shifted[VW-N-1];
    s2_next.s      = (|shifted[VW-N-2:0]) | s1.sticky;
    s2_next.sat_hi = s1.sat_hi;
    s2_next.sat_lo = s1.sat_lo;
    s2_next.zero   = s1.zero;
    s2_next.nar    = s1.nar;
  end

  // Stage 3
  logic [N-2:0] rounded, body_f;
  logic         ovf;
  logic [N-1:0] mag, res;

  posit_round_rne #(.BW(N - 1)) u_round (
    .body    (s2.body),
    .l       (s2.body[0]),
    .g       (s2.g),
    .r       (s2.r),
    .s       (s2.s),
    .rounded (rounded),
    .ovf     (ovf)
  );

  always_comb begin
    if (s2.sat_hi)      body_f = MAXPOS;
    else if (s2.sat_lo) body_f = MINPOS;
    else                body_f = rounded;
    mag = {1'b0, body_f};
    if (s2.nar)       res = NAR;
    else if (s2.zero) res = '0;
    else              res = s2.sign ? -mag : mag;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      s1        <= '0;
      s2        <= '0;
      out_valid <= 1'b0;
      out_posit <= '0;
    end else if (adv) begin
      v1        <= in_valid;
      s1        <= s1_next;
      v2        <= v1;
      s2        <= s2_next;
      out_valid <= v2;
      out_posit <= res;
    end
  end

endmodule

// File: tb/tb_posit_encoder_pipe.sv
// Self-checking bench for posit_encoder_pipe (N=8, ES=3): directed cases, flow control,
// reset and randomized traffic against an arithmetic reference model with a scoreboard.
module tb_posit_encoder_pipe;
  import posit_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] out_posit;
  posit_dec_t cur;

  logic [7:0] exp_q[$];
  int         acc_q[$];
  int         pop_cyc_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         pops = 0;
  int         last_lat = 0;

  always #5 clk = ~clk;

  posit_encoder_pipe #(.N(8), .ES(3)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sign   (cur.sign),
    .in_scale  (cur.scale),
    .in_frac   (cur.frac),
    .in_sticky (cur.sticky),
    .in_zero   (cur.zero),
    .in_nar    (cur.nar),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  // Reference: build the regime/exponent/fraction bit string as an integer and round by
  // comparing the discarded remainder against one half ulp.
  function automatic logic [7:0] model(posit_dec_t d);
    int     sc, k, e, rl, len;
    longint regv, bits, body, rem, half;
    if (d.nar)  return POSIT_NAR;
    if (d.zero) return POSIT_ZERO;
    sc = int'($signed(d.scale));
    k  = (sc >= 0) ? sc / 8 : -((-sc + 7) / 8);
    e  = sc - 8 * k;
    if (k > 6)       body = 127;
    else if (k < -6) body = 1;
    else begin
      if (k >= 0) begin regv = ((64'd1 << (k + 1)) - 1) << 1; rl = k + 2; end
      else        begin regv = 1; rl = 1 - k; end
      bits = (regv << 11) | (longint'(e) << 8) | longint'(d.frac);
      len  = rl + 11;
      body = bits >> (len - 7);
      rem  = bits & ((64'd1 << (len - 7)) - 1);
      half = 64'd1 << (len - 8);
      if (rem > half || (rem == half && (d.sticky || body[0]))) body = body + 1;
      if (body == 128) body = 127;
    end
    return d.sign ? 8'(256 - body) : 8'(body);
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: sample handshakes settled after input changes, then account for the edge.
  task automatic step();
    logic       fin, fout;
    logic [7:0] obs, e;
    int         a;
    #1;
    fin  = in_valid && in_ready;
    fout = out_valid && out_ready;
    obs  = out_posit;
    @(posedge clk);
    #1;
    cyc++;
    if (fin) begin
      exp_q.push_back(model(cur));
      acc_q.push_back(cyc);
    end
    if (fout) begin
      total++;
      assert (exp_q.size() > 0) else begin
        bad++;
        $error("FAIL ghost observed=%0h expected=none", obs);
      end
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        last_lat = cyc - a;
        pops++;
        pop_cyc_q.push_back(cyc);
        chk("scoreboard", obs, e);
      end
    end
  endtask

  task automatic set_beat(input logic s, input int sc, input logic [7:0] f,
                          input logic st, input logic z, input logic n);
    cur.sign   = s;
    cur.scale  = 7'(sc);
    cur.frac   = f;
    cur.sticky = st;
    cur.zero   = z;
    cur.nar    = n;
  endtask

  task automatic directed(input string tag, input logic s, input int sc, input logic [7:0] f,
                          input logic st, input logic z, input logic n, input logic [7:0] expv);
    set_beat(s, sc, f, st, z, n);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    chk({tag, "_early"}, {7'b0, out_valid}, 8'd0);
    step();
    chk({tag, "_valid"}, {7'b0, out_valid}, 8'd1);
    chk(tag, out_posit, expv);
    step();
    chk({tag, "_lat"}, 8'(last_lat), 8'd3);
  endtask

  task automatic rand_beat();
    set_beat(1'($urandom), int'($urandom_range(0, 127)), 8'($urandom), 1'($urandom),
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
  endtask

  initial begin
    int p0;
    n_rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cur = '0;
    #12;
    chk("rst_out_valid", {7'b0, out_valid}, 8'd0);
    chk("rst_out_posit", out_posit, 8'h00);
    chk("rst_in_ready", {7'b0, in_ready}, 8'd1);
    n_rst = 1'b1;

    directed("scale0",      1'b0,   0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h40);
    directed("scale8",      1'b0,   8, 8'h00, 1'b0, 1'b0, 1'b0, 8'h60);
    directed("scale_m1",    1'b0,  -1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C);
    directed("neg_scale0",  1'b1,   0, 8'h00, 1'b0, 1'b0, 1'b0, 8'hC0);
    directed("nar_zero",    1'b0,   0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h80);
    directed("zero",        1'b1,   5, 8'hAA, 1'b1, 1'b1, 1'b0, 8'h00);
    directed("sat_hi",      1'b0,  63, 8'h00, 1'b0, 1'b0, 1'b0, 8'h7F);
    directed("sat_lo",      1'b0, -63, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01);
    directed("neg_sat_hi",  1'b1,  63, 8'h00, 1'b0, 1'b0, 1'b0, 8'h81);
    directed("rnd_up",      1'b0,   0, 8'h30, 1'b0, 1'b0, 1'b0, 8'h41);
    directed("tie_even",    1'b0,   0, 8'h20, 1'b0, 1'b0, 1'b0, 8'h40);
    directed("tie_sticky",  1'b0,   0, 8'h20, 1'b1, 1'b0, 1'b0, 8'h41);
    directed("tie_odd",     1'b0,   0, 8'h60, 1'b0, 1'b0, 1'b0, 8'h42);
    directed("near_max",    1'b0,  47, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h7F);
    directed("minpos_k6",   1'b0, -48, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h01);

    // Back-to-back: 8 beats, results on 8 consecutive cycles.
    pop_cyc_q.delete();
    for (int i = 0; i < 8; i++) begin
      rand_beat();
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) step();
    chk("b2b_count", 8'(pop_cyc_q.size()), 8'd8);
    for (int j = 1; j < pop_cyc_q.size(); j++)
      chk("b2b_gap", 8'(pop_cyc_q[j] - pop_cyc_q[j-1]), 8'd1);

    // Stall: three beats fill the pipe with out_ready low, a fourth waits.
    p0 = pops;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b0, 8 * i - 4, 8'(16 * i + 3), 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      step();
    end
    set_beat(1'b1, 20, 8'h5A, 1'b1, 1'b0, 1'b0);
    #1;
    chk("stall_in_ready", {7'b0, in_ready}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", {7'b0, out_valid}, 8'd1);
      chk("stall_hold", out_posit, exp_q[0]);
      chk("stall_in_ready_hold", {7'b0, in_ready}, 8'd0);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) step();
    chk("stall_drain_left", 8'(exp_q.size()), 8'd0);
    chk("stall_drain_count", 8'(pops - p0), 8'd4);

    // Randomized traffic with random bubbles and back-pressure.
    for (int i = 0; i < 400; i++) begin
      rand_beat();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12 && exp_q.size() > 0; i++) step();
    chk("rand_drain_left", 8'(exp_q.size()), 8'd0);

    // Reset with beats in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_beat(1'b0, i, 8'h00, 1'b0, 1'b0, 1'b0);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    chk("pre_rst_valid", {7'b0, out_valid}, 8'd1);
    #2;
    n_rst = 1'b0;
    #1;
    chk("mid_rst_valid", {7'b0, out_valid}, 8'd0);
    chk("mid_rst_posit", out_posit, 8'h00);
    chk("mid_rst_in_ready", {7'b0, in_ready}, 8'd1);
    exp_q.delete();
    acc_q.delete();
    step();
    step();
    n_rst = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("no_ghost", {7'b0, out_valid}, 8'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
